// File: rtl/stage4_memory_if.sv
// stage4_memory_if: bundles the three streams around the memory-access stage.
//   in_*   : execute -> stage instruction stream (valid/ready)
//   out_*  : stage -> writeback result stream (valid/ready)
//   mem_*  : stage -> data memory request port (req held until a one-cycle ack)
// Handshake rule for both valid/ready streams: a transfer happens on a rising
// clock edge where valid && ready are both 1. Once raised, valid and the
// payload stay stable until that transfer.
// Modports:
//   master : the memory stage itself
//   slave  : its environment (execute, writeback and the data memory)
interface stage4_memory_if #(
  parameter int REGISTER_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [6:0]                in_opcode;
  logic [2:0]                in_funct3;
  logic [4:0]                in_rd;
  logic [REGISTER_WIDTH-1:0] in_alu_result;
  logic [REGISTER_WIDTH-1:0] in_store_data;
  logic [REGISTER_WIDTH-1:0] in_branch_target;

  logic                      out_valid;
  logic                      out_ready;
  logic [6:0]                out_opcode;
  logic [2:0]                out_funct3;
  logic [4:0]                out_rd;
  logic [REGISTER_WIDTH-1:0] out_alu_result;
  logic [REGISTER_WIDTH-1:0] out_branch_target;
  logic [REGISTER_WIDTH-1:0] out_data_from_memory;

  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [REGISTER_WIDTH-1:0] mem_wdata;
  logic [3:0]                mem_wstrb;
  logic                      mem_ack;
  logic [REGISTER_WIDTH-1:0] mem_rdata;

  modport master (
    input  in_valid, in_opcode, in_funct3, in_rd, in_alu_result,
           in_store_data, in_branch_target,
    output in_ready,
    output out_valid, out_opcode, out_funct3, out_rd, out_alu_result,
           out_branch_target, out_data_from_memory,
    input  out_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output in_valid, in_opcode, in_funct3, in_rd, in_alu_result,
           in_store_data, in_branch_target,
    input  in_ready,
    input  out_valid, out_opcode, out_funct3, out_rd, out_alu_result,
           out_branch_target, out_data_from_memory,
    output out_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/stage4_memory.sv
// stage4_memory: memory-access pipeline stage between execute and writeback.
// Non-memory instructions pass through a single output register (one per
// cycle). Loads/stores issue one request to data memory, wait for the ack,
// then present the result; load data is shifted down to bit 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : stage4_memory_if.master (in_*, out_*, mem_* streams)
//   dbg_state : current FSM state (IDLE=0, MEM_WAIT=1, OUT_HOLD=2)
module stage4_memory #(
  parameter int REGISTER_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  stage4_memory_if.master       bus,
  output logic [1:0]            dbg_state
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    OUT_HOLD = 2'd2
  } state_t;

  state_t state, state_next;

  // Holds in_ready low while in reset and for the first edge after it.
  logic ready_en;

  logic in_ready_c;
  logic accept;
  logic is_mem;
  logic mem_done;
  logic mem_req_c;

  logic                      out_valid_q;
  logic [6:0]                out_opcode_q;
  logic [2:0]                out_funct3_q;
  logic [4:0]                out_rd_q;
  logic [REGISTER_WIDTH-1:0] out_alu_result_q;
  logic [REGISTER_WIDTH-1:0] out_branch_target_q;
  logic [REGISTER_WIDTH-1:0] out_data_q;
  logic [1:0]                off_q;

  logic                      mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [REGISTER_WIDTH-1:0] mem_wdata_q;
  logic [3:0]                mem_wstrb_q;

  logic [REGISTER_WIDTH-1:0] wdata_c;
  logic [3:0]                wstrb_c;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    mem_done   = 1'b0;
    mem_req_c  = 1'b0;
    is_mem     = (bus.in_opcode == OP_LOAD) || (bus.in_opcode == OP_STORE);
    case (state)
      IDLE: begin
        // A pending result may be replaced in the same edge it is taken.
        in_ready_c = ready_en && (!out_valid_q || bus.out_ready);
        accept     = in_ready_c && bus.in_valid;
        if (accept && is_mem) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_req_c = 1'b1;
        if (bus.mem_ack) begin
          mem_done   = 1'b1;
          state_next = OUT_HOLD;
        end
      end
      OUT_HOLD: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- store lane encoding ----------------
  // Sub-word stores replicate the data across lanes so memory only needs
  // the strobes; offset bits below the access size are ignored.
  always_comb begin
    wdata_c = '0;
    wstrb_c = 4'b0000;
    if (bus.in_opcode == OP_STORE) begin
      case (bus.in_funct3[1:0])
        2'b00: begin
          wdata_c = {4{bus.in_store_data[7:0]}};
          wstrb_c = 4'b0001 << bus.in_alu_result[1:0];
        end
        2'b01: begin
          wdata_c = {2{bus.in_store_data[15:0]}};
          wstrb_c = 4'b0011 << {bus.in_alu_result[1], 1'b0};
        end
        default: begin
          wdata_c = bus.in_store_data;
          wstrb_c = 4'b1111;
        end
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q         <= 1'b0;
      out_opcode_q        <= '0;
      out_funct3_q        <= '0;
      out_rd_q            <= '0;
      out_alu_result_q    <= '0;
      out_branch_target_q <= '0;
      out_data_q          <= '0;
      off_q               <= '0;
      mem_we_q            <= 1'b0;
      mem_addr_q          <= '0;
      mem_wdata_q         <= '0;
      mem_wstrb_q         <= '0;
    end else begin
      if (accept) begin
        out_opcode_q        <= bus.in_opcode;
        out_funct3_q        <= bus.in_funct3;
        out_rd_q            <= bus.in_rd;
        out_alu_result_q    <= bus.in_alu_result;
        out_branch_target_q <= bus.in_branch_target;
        out_data_q          <= '0;
        off_q               <= bus.in_alu_result[1:0];
        // Memory ops present their result only after the ack.
        out_valid_q         <= !is_mem;
        if (is_mem) begin
          mem_we_q    <= (bus.in_opcode == OP_STORE);
          mem_addr_q  <= {bus.in_alu_result[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_q <= wdata_c;
          mem_wstrb_q <= wstrb_c;
        end
      end else if (mem_done) begin
        out_valid_q <= 1'b1;
        if (out_opcode_q == OP_LOAD) out_data_q <= bus.mem_rdata >> {off_q, 3'b000};
        else                         out_data_q <= '0;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready             = in_ready_c;
  assign bus.out_valid            = out_valid_q;
  assign bus.out_opcode           = out_opcode_q;
  assign bus.out_funct3           = out_funct3_q;
  assign bus.out_rd               = out_rd_q;
  assign bus.out_alu_result       = out_alu_result_q;
  assign bus.out_branch_target    = out_branch_target_q;
  assign bus.out_data_from_memory = out_data_q;
  assign bus.mem_req              = mem_req_c;
  assign bus.mem_we               = mem_we_q;
  assign bus.mem_addr             = mem_addr_q;
  assign bus.mem_wdata            = mem_wdata_q;
  assign bus.mem_wstrb            = mem_wstrb_q;
  assign dbg_state                = state;

endmodule

// File: doc/stage4_memory.md
Name: stage4_memory

Overview:
- Memory-access pipeline stage between execute and writeback.
- Accepts executed instructions on a valid/ready stream.
- Loads and stores go to the data memory over a req/ack port. Every instruction is forwarded to writeback on the memory-to-writeback valid/ready stream.
- This is the transmitter end of the memory-to-writeback stream. Load data is lane-aligned to bit 0, so writeback only sign/zero-extends.

Parameters:
- REGISTER_WIDTH, 32, data/register width; only 32 is supported.
- ADDR_WIDTH, 32, data memory byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute stage offers an instruction
- in_ready  out  1  stage can accept an instruction
- in_opcode  in  7  decoded opcode
- in_funct3  in  3  decoded funct3
- in_rd  in  5  destination register
- in_alu_result  in  REGISTER_WIDTH  ALU result; the effective address for load/store
- in_store_data  in  REGISTER_WIDTH  rs2 value for stores
- in_branch_target  in  REGISTER_WIDTH  link/branch target
- out_valid  out  1  writeback payload valid
- out_ready  in  1  writeback accepts
- out_opcode, out_funct3, out_rd, out_alu_result, out_branch_target  out  7/3/5/W/W  registered copies of the inputs
- out_data_from_memory  out  REGISTER_WIDTH  aligned load data; 0 for non-loads
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_WIDTH  word address: effective address with bits [1:0] = 0
- mem_wdata  out  REGISTER_WIDTH  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  one-cycle completion pulse
- mem_rdata  in  REGISTER_WIDTH  read word, valid with mem_ack

Behaviour:
- Reset: state IDLE and all outputs 0, including in_ready. in_ready goes to 1 on the first cycle after reset deassertion.
- FSM states:
  - IDLE: waiting for an instruction.
  - MEM_WAIT: memory request outstanding.
  - OUT_HOLD: output waiting to be taken.
- out_valid is a register. It is 1 in OUT_HOLD, and also in IDLE when the previous result is still pending and not yet taken.
- Accept condition: in_ready = (state==IDLE) && (!out_valid || out_ready). A transfer happens when in_valid && in_ready.
- Non-memory opcode accepted:
  - Fields are registered into out_*; out_data_from_memory = 0; out_valid = 1 next cycle (latency 1). State stays IDLE.
  - Back-to-back throughput is one instruction per cycle while out_ready = 1.
- OP_LOAD or OP_STORE accepted:
  - Fields are captured and the state moves to MEM_WAIT.
  - The output slot is drained in the same cycle if out_ready = 1.
  - mem_req = 1 from the next cycle. mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_ack.
- Let off = effective address [1:0].
- Store encoding:
  - SB: wdata = byte replicated 4x; wstrb = 0001 << off.
  - SH: wdata = halfword replicated 2x; wstrb = 0011 << {off[1],1'b0}.
  - SW: wdata = store_data; wstrb = 1111.
- Loads: mem_we = 0, wstrb = 0000.
- Misalignment is not detected. Bits below the access size are ignored as shown above.
- On mem_ack in MEM_WAIT:
  - mem_req drops in the same cycle (combinational from state); no further request is issued.
  - Load: out_data_from_memory = mem_rdata >> (8*off), zero-filled at the top.
  - Store: out_data_from_memory = 0.
  - out_valid = 1 next cycle; state moves to OUT_HOLD.
- OUT_HOLD: out_* stay stable while out_valid && !out_ready. On out_ready, state goes to IDLE and out_valid = 0 unless a new instruction is accepted in the same cycle.
- mem_ack outside MEM_WAIT is ignored.
- Memory latency is unbounded; there is no timeout.
- Reset asserted mid-operation: mem_req and out_valid go to 0 immediately and the state returns to IDLE. An ack that arrives after reset is ignored.

Test Plan:
- ADDI result 0x00000005, rd = 3, out_ready = 1 → out_valid the next cycle; out_alu_result = 5, out_rd = 3, out_data_from_memory = 0; no mem_req.
- LB at address 0x103, ack after 3 cycles with rdata 0x80AABBCC → mem_addr = 0x100 held for all 3 cycles, mem_we = 0; out_data_from_memory = 0x00000080 one cycle after ack.
- SH at address 0x102 with store_data 0xFFFF1234 → mem_wdata = 0x12341234, mem_wstrb = 1100, mem_we = 1; out_data_from_memory = 0 after ack.
- Two ADDIs back-to-back with out_ready = 0 for 4 cycles → first result held stable, in_ready = 0; after out_ready rises, both results delivered in order with no loss.
- rst pulsed during MEM_WAIT, then mem_ack asserted → mem_req and out_valid go to 0 immediately; the late ack produces no output; the next ADDI flows normally.
- SW at address 0x200 with data 0xDEADBEEF immediately followed by LW at 0x200 → mem_wstrb = 1111; the LW is not accepted (in_ready = 0) until the store's ack; the LW is issued only after that ack.
